dac_spi_sched: RTL and testbench

Scheduler that shares the single DAC configuration SPI engine among three requesters: frame-hop frequency updates, host register writes and host register reads. Sits between the frame timing logic, the DSP/UART register path and the DAC SPI engine. Grants one transaction at a time, builds the 40-bit SPI word and, after every write, drives the IO_UPDATE request for a programmable time. Also enforces a minimum chip-select gap and recovers from a hung engine.

---
 rtl/dac_cfg_pkg.sv | 38 +++
 rtl/dac_spi_sched_if.sv | 23 ++
 rtl/dac_sched_arb.sv | 19 +
 rtl/dac_spi_sched.sv | 145 ++++++++++++++
 tb/tb_dac_spi_sched.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_cfg_pkg.sv
// Shared types for the DAC configuration SPI scheduler: FSM states, grant
// codes and the 40-bit engine word layout.
package dac_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_IOUP  = 3'd3,
    ST_GAP   = 3'd4
  } sched_st_e;

  typedef enum logic [1:0] {
    GNT_HOP = 2'd0,
    GNT_WR  = 2'd1,
    GNT_RD  = 2'd2
  } gnt_e;

  localparam int WORD_W  = 40;
  localparam int RW_BIT  = 39;
  localparam int ADDR_HI = 38;
  localparam int ADDR_LO = 32;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
  localparam int DATA_W  = 32;

  // Packed so that rw lands on bit 39, addr on 38:32 and data on 31:0.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_word_t;

  function automatic spi_word_t mk_word(input logic rw, input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/dac_spi_sched_if.sv
// Scheduler-to-engine link: start/word/abort toward the SPI engine, done and
// read data back, plus the IO_UPDATE request level.
interface dac_spi_sched_if;
  import dac_cfg_pkg::*;

  logic              eng_start;
  spi_word_t         eng_word;
  logic              eng_done;
  logic [DATA_W-1:0] eng_rd_data;
  logic              eng_abort;
  logic              ioup_req;

  modport master (
    output eng_start, eng_word, eng_abort, ioup_req,
    input  eng_done, eng_rd_data
  );

  modport slave (
    input  eng_start, eng_word, eng_abort, ioup_req,
    output eng_done, eng_rd_data
  );

endinterface

// File: rtl/dac_sched_arb.sv
// Three-way arbiter: hop has fixed top priority, host write/read share the
// remaining slot round-robin. One-hot grant {rd, wr, hop}.
module dac_sched_arb (
  input  logic       hop_i,
  input  logic       wr_i,
  input  logic       rd_i,
  input  logic       last_rd_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    if (hop_i)             gnt_o = 3'b001;
    else if (wr_i && rd_i) gnt_o = last_rd_i ? 3'b010 : 3'b100;
    else if (wr_i)         gnt_o = 3'b010;
    else if (rd_i)         gnt_o = 3'b100;
  end

endmodule

// File: rtl/dac_spi_sched.sv
// Shares the DAC config SPI engine among frame-hop FTW writes and host
// register writes/reads; handles IO_UPDATE, CS gap and engine timeout.
module dac_spi_sched
  import dac_cfg_pkg::*;
#(
  parameter logic [7:0]  HOP_ADDR = 8'h0E,
  parameter int unsigned GAP_CYC  = 4,
  parameter logic [15:0] TMO_CYC  = 16'd2000
) (
  input  logic                cfg_spi_clk,
  input  logic                cfg_rst_in,
  input  logic                hop_req,
  input  logic [DATA_W-1:0]   hop_data,
  input  logic                host_wr_req,
  input  logic [ADDR_W-1:0]   host_wr_addr,
  input  logic [DATA_W-1:0]   host_wr_data,
  output logic                host_wr_ack,
  input  logic                host_rd_req,
  input  logic [ADDR_W-1:0]   host_rd_addr,
  output logic [DATA_W-1:0]   host_rd_data,
  output logic                host_rd_valid,
  input  logic [7:0]          ioup_len,
  dac_spi_sched_if.master     eng,
  output logic                busy,
  output logic                hop_overrun,
  output logic                err_tmo
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [15:0] TMO_LAST = TMO_CYC - 16'd1;

  sched_st_e         st_q, st_d;
  logic [15:0]       cnt_q, cnt_d;
  gnt_e              gnt_q, gnt_d;
  spi_word_t         word_q, word_d;
  logic              hop_pend_q, hop_ovr_q, last_rd_q;
  logic [DATA_W-1:0] hop_buf_q;
  logic [7:0]        len_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_ack_q, rd_vld_q, abort_q, tmo_q;
  logic [2:0]        gnt;
  logic              grant, grant_hop, done_ev, tmo_ev;

  dac_sched_arb u_arb (
    .hop_i     (hop_pend_q),
    .wr_i      (host_wr_req),
    .rd_i      (host_rd_req),
    .last_rd_i (last_rd_q),
    .gnt_o     (gnt)
  );

  assign grant     = (st_q == ST_IDLE) && (|gnt);
  assign grant_hop = grant && gnt[0];
  assign done_ev   = (st_q == ST_WAIT) && eng.eng_done;
  assign tmo_ev    = (st_q == ST_WAIT) && !eng.eng_done && (cnt_q == TMO_LAST);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (|gnt) st_d = ST_ISSUE;
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT: begin
        if (eng.eng_done)
          st_d = (gnt_q != GNT_RD && ioup_len != 8'd0) ? ST_IOUP : ST_GAP;
        else if (cnt_q == TMO_LAST)
          st_d = ST_GAP;
      end
      ST_IOUP:  if (cnt_q == {8'd0, len_q} - 16'd1) st_d = ST_GAP;
      ST_GAP:   if (cnt_q == GAP_LAST) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  // One timer serves timeout, IO_UPDATE width and gap; restarts on every state change.
  assign cnt_d = (st_d != st_q || st_q == ST_IDLE) ? 16'd0 : cnt_q + 16'd1;

  always_comb begin
    word_d = word_q;
    gnt_d  = gnt_q;
    if (grant) begin
      if (gnt[0]) begin
        word_d = mk_word(1'b0, HOP_ADDR[ADDR_W-1:0], hop_buf_q);
        gnt_d  = GNT_HOP;
      end else if (gnt[1]) begin
        word_d = mk_word(1'b0, host_wr_addr, host_wr_data);
        gnt_d  = GNT_WR;
      end else begin
        word_d = mk_word(1'b1, host_rd_addr, '0);
        gnt_d  = GNT_RD;
      end
    end
  end

  always_ff @(posedge cfg_spi_clk or posedge cfg_rst_in) begin
    if (cfg_rst_in) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= GNT_HOP;
      word_q     <= '0;
      hop_pend_q <= 1'b0;
      hop_ovr_q  <= 1'b0;
      hop_buf_q  <= '0;
      last_rd_q  <= 1'b1;
      len_q      <= '0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      abort_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      word_q <= word_d;
      // A pulse landing in the grant cycle re-arms pending with the new data.
      if (hop_req) begin
        hop_pend_q <= 1'b1;
        hop_buf_q  <= hop_data;
      end else if (grant_hop) begin
        hop_pend_q <= 1'b0;
      end
      if (hop_req && hop_pend_q && !grant_hop) hop_ovr_q <= 1'b1;
      if (grant && gnt[1]) last_rd_q <= 1'b0;
      if (grant && gnt[2]) last_rd_q <= 1'b1;
      if (done_ev) len_q <= ioup_len;
      if (done_ev && gnt_q == GNT_RD) rd_data_q <= eng.eng_rd_data;
      wr_ack_q <= done_ev && (gnt_q == GNT_WR);
      rd_vld_q <= done_ev && (gnt_q == GNT_RD);
      abort_q  <= tmo_ev;
      tmo_q    <= tmo_ev;
    end
  end

  assign eng.eng_start = (st_q == ST_ISSUE);
  assign eng.eng_word  = word_q;
  assign eng.eng_abort = abort_q;
  assign eng.ioup_req  = (st_q == ST_IOUP);
  assign busy          = (st_q != ST_IDLE);
  assign hop_overrun   = hop_ovr_q;
  assign err_tmo       = tmo_q;
  assign host_wr_ack   = wr_ack_q;
  assign host_rd_valid = rd_vld_q;
  assign host_rd_data  = rd_data_q;

endmodule

// File: tb/tb_dac_spi_sched.sv
// Randomized bench for dac_spi_sched: acts as SPI engine and host, and
// predicts grant order, words and phase lengths from a transaction-level model.
module tb_dac_spi_sched;
  localparam int GAP   = 4;
  localparam int TMO   = 2000;
  localparam int T_HOP = 0;
  localparam int T_WR  = 1;
  localparam int T_RD  = 2;

  logic        cfg_spi_clk = 1'b0;
  logic        cfg_rst_in  = 1'b0;
  logic        hop_req = 1'b0;
  logic [31:0] hop_data = '0;
  logic        host_wr_req = 1'b0;
  logic [6:0]  host_wr_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic        host_wr_ack;
  logic        host_rd_req = 1'b0;
  logic [6:0]  host_rd_addr = '0;
  logic [31:0] host_rd_data;
  logic        host_rd_valid;
  logic [7:0]  ioup_len = '0;
  logic        busy, hop_overrun, err_tmo;

  dac_spi_sched_if eng();

  dac_spi_sched #(.HOP_ADDR(8'h0E), .GAP_CYC(GAP), .TMO_CYC(16'(TMO))) dut (
    .cfg_spi_clk   (cfg_spi_clk),
    .cfg_rst_in    (cfg_rst_in),
    .hop_req       (hop_req),
    .hop_data      (hop_data),
    .host_wr_req   (host_wr_req),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_wr_ack   (host_wr_ack),
    .host_rd_req   (host_rd_req),
    .host_rd_addr  (host_rd_addr),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .ioup_len      (ioup_len),
    .eng           (eng),
    .busy          (busy),
    .hop_overrun   (hop_overrun),
    .err_tmo       (err_tmo)
  );

  always #5 cfg_spi_clk = ~cfg_spi_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_hop_pend = 0;
  bit          m_ovr      = 0;
  bit          m_last_rd  = 1;
  bit          wr_held    = 0;
  bit          rd_held    = 0;
  logic [31:0] m_hop_buf  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cfg_spi_clk);
    #1;
  endtask

  task automatic raise_wr();
    host_wr_addr = 7'($urandom);
    host_wr_data = $urandom;
    host_wr_req  = 1'b1;
    wr_held      = 1;
  endtask

  task automatic raise_rd();
    host_rd_addr = 7'($urandom);
    host_rd_req  = 1'b1;
    rd_held      = 1;
  endtask

  task automatic pulse_hop(input logic [31:0] d);
    hop_data = d;
    hop_req  = 1'b1;
    if (m_hop_pend) m_ovr = 1;
    m_hop_pend = 1;
    m_hop_buf  = d;
    tick();
    hop_req = 1'b0;
  endtask

  // Expected next grant: pending hop first, else alternate between held host requests.
  task automatic pick(output logic [39:0] w, output int typ);
    if (m_hop_pend) begin
      w = {1'b0, 7'h0E, m_hop_buf}; typ = T_HOP; m_hop_pend = 0;
    end else if (wr_held && (!rd_held || m_last_rd)) begin
      w = {1'b0, host_wr_addr, host_wr_data}; typ = T_WR; m_last_rd = 0;
    end else begin
      w = {1'b1, host_rd_addr, 32'd0}; typ = T_RD; m_last_rd = 1;
    end
  endtask

  task automatic wait_start(output bit seen);
    int n;
    n = 0;
    while (!eng.eng_start && n < 100) begin
      tick();
      n++;
    end
    seen = eng.eng_start;
  endtask

  task automatic inject_reqs();
    if ($urandom_range(0, 2) == 0) begin
      pulse_hop($urandom);
      if ($urandom_range(0, 5) == 0) pulse_hop($urandom);
    end
    if (!wr_held && $urandom_range(0, 1) == 1) raise_wr();
    if (!rd_held && $urandom_range(0, 1) == 1) raise_rd();
  endtask

  // Entered on the eng_start cycle; ends back in IDLE.
  task automatic finish_txn(input int typ, input bit inject);
    logic [31:0] rd;
    int len, ioc, gapc, spur, n;
    tick();
    if (inject) inject_reqs();
    repeat ($urandom_range(0, 4)) tick();
    rd = $urandom;
    eng.eng_rd_data = rd;
    eng.eng_done    = 1'b1;
    len = int'(ioup_len);
    tick();
    eng.eng_done = 1'b0;
    ioup_len     = 8'($urandom_range(0, 6));
    chk("wr_ack", 64'(host_wr_ack), 64'(typ == T_WR));
    chk("rd_vld", 64'(host_rd_valid), 64'(typ == T_RD));
    if (typ == T_RD) chk("rd_data", 64'(host_rd_data), 64'(rd));
    if (typ == T_WR) begin host_wr_req = 1'b0; wr_held = 0; end
    if (typ == T_RD) begin host_rd_req = 1'b0; rd_held = 0; end
    ioc = 0; gapc = 0; spur = 0; n = 0;
    while (busy && n < 500) begin
      if (n > 0 && (host_wr_ack || host_rd_valid)) spur++;
      if (eng.ioup_req) ioc++;
      else gapc++;
      eng.eng_done = (n == 0) && ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    eng.eng_done = 1'b0;
    chk("ioup_cyc", 64'(ioc), 64'((typ == T_RD) ? 0 : len));
    chk("gap_cyc", 64'(gapc), 64'(GAP));
    chk("spurious", 64'(spur), 64'd0);
    chk("overrun", 64'(hop_overrun), 64'(m_ovr));
  endtask

  task automatic do_txn(input bit inject);
    logic [39:0] w;
    int typ;
    bit seen;
    pick(w, typ);
    wait_start(seen);
    chk("start", 64'(seen), 64'd1);
    chk("word", 64'(eng.eng_word), 64'(w));
    finish_txn(typ, inject);
  endtask

  task automatic new_req();
    int c;
    if ($urandom_range(0, 3) == 0) pulse_hop($urandom);
    else begin
      c = $urandom_range(1, 3);
      if (c[0]) raise_wr();
      if (c[1]) raise_rd();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [39:0] w;
    int typ, n, acks;
    bit seen;
    eng.eng_done    = 1'b0;
    eng.eng_rd_data = '0;
    #1 cfg_rst_in = 1'b1;
    #2;
    chk("rst_start", 64'(eng.eng_start), 64'd0);
    chk("rst_word", 64'(eng.eng_word), 64'd0);
    chk("rst_abort", 64'(eng.eng_abort), 64'd0);
    chk("rst_ioup", 64'(eng.ioup_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(hop_overrun), 64'd0);
    chk("rst_tmo", 64'(err_tmo), 64'd0);
    chk("rst_ack", 64'(host_wr_ack), 64'd0);
    chk("rst_vld", 64'(host_rd_valid), 64'd0);
    chk("rst_rdata", 64'(host_rd_data), 64'd0);
    tick();
    cfg_rst_in = 1'b0;
    tick();

    // Frame hop: start two cycles after the pulse, IO_UPDATE 8 cycles
    ioup_len = 8'd8;
    pulse_hop(32'h1000_0000);
    tick();
    chk("hop_lat", 64'(eng.eng_start), 64'd1);
    chk("hop_word", 64'(eng.eng_word), 64'h0E_1000_0000);
    do_txn(0);

    for (int k = 0; k < 40; k++) begin
      if (!(m_hop_pend || wr_held || rd_held)) new_req();
      do_txn(1);
    end
    while (m_hop_pend || wr_held || rd_held) do_txn(0);

    // Hung engine: abort after the timeout, held write goes out again
    raise_wr();
    pick(w, typ);
    wait_start(seen);
    chk("tmo_start", 64'(seen), 64'd1);
    chk("tmo_word", 64'(eng.eng_word), 64'(w));
    tick();
    n = 0; acks = 0;
    while (!err_tmo && n < 2100) begin
      if (host_wr_ack) acks++;
      tick();
      n++;
    end
    chk("tmo_cyc", 64'(n), 64'(TMO));
    chk("tmo_abort", 64'(eng.eng_abort), 64'd1);
    chk("tmo_noack", 64'(acks), 64'd0);
    tick();
    chk("tmo_pulse", 64'(err_tmo), 64'd0);
    do_txn(0);

    // Reset during IO_UPDATE; the pending read restarts afterwards
    ioup_len = 8'd8;
    raise_wr();
    pick(w, typ);
    wait_start(seen);
    chk("rst2_word", 64'(eng.eng_word), 64'(w));
    tick();
    raise_rd();
    repeat (2) tick();
    eng.eng_rd_data = $urandom;
    eng.eng_done    = 1'b1;
    tick();
    eng.eng_done = 1'b0;
    chk("rst2_ack", 64'(host_wr_ack), 64'd1);
    host_wr_req = 1'b0; wr_held = 0;
    repeat (3) tick();
    chk("rst2_pre", 64'(eng.ioup_req), 64'd1);
    #2 cfg_rst_in = 1'b1;
    #1;
    chk("rst2_ioup", 64'(eng.ioup_req), 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_start", 64'(eng.eng_start), 64'd0);
    m_hop_pend = 0; m_ovr = 0; m_last_rd = 1;
    @(posedge cfg_spi_clk);
    #1 cfg_rst_in = 1'b0;
    do_txn(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
